// File: rtl/video_source_scheduler.sv
// Shares one video output between four pixel sources. Source changes happen only
// at frame ends, and black frames can be inserted between sources.
module video_source_scheduler #(
    parameter int H_ACTIVE     = 800,
    parameter int V_ACTIVE     = 600,
    parameter int DWELL_FRAMES = 60,
    parameter int BLACK_FRAMES = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VideoReady,
    input  logic [23:0] Src0Video,
    input  logic [23:0] Src1Video,
    input  logic [23:0] Src2Video,
    input  logic [23:0] Src3Video,
    output logic [3:0]  SrcReady,
    output logic [23:0] video,
    input  logic        AutoCycle,
    input  logic        SelValid,
    input  logic [1:0]  SelIndex,
    output logic        SelBusy,
    output logic [1:0]  CurrentSel,
    output logic        FrameDone,
    output logic [15:0] FrameCount
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int BW = (BLACK_FRAMES > 1) ? $clog2(BLACK_FRAMES) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [BW-1:0] BLACK_LAST = BW'((BLACK_FRAMES > 0) ? BLACK_FRAMES - 1 : 0);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic [BW-1:0] black_cnt, black_n;
    logic [1:0]    target, target_n, sel_n;
    logic          frame_end;
    logic          switch_now;
    logic [23:0]   src_pix;

    assign frame_end = VideoReady && (x == X_LAST) && (y == Y_LAST);

    always_comb begin
        case (CurrentSel)
            2'd0:    src_pix = Src0Video;
            2'd1:    src_pix = Src1Video;
            2'd2:    src_pix = Src2Video;
            default: src_pix = Src3Video;
        endcase
    end

    // Blanking starves every source so all of them stay frame-aligned.
    assign video    = (state == ST_BLANK) ? 24'h000000 : src_pix;
    assign SrcReady = (state == ST_BLANK) ? 4'b0000 : ({3'b000, VideoReady} << CurrentSel);
    assign SelBusy  = (state != ST_ACTIVE);

    always_comb begin
        state_n    = state;
        target_n   = target;
        sel_n      = CurrentSel;
        dwell_n    = dwell_cnt;
        black_n    = black_cnt;
        switch_now = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (SelValid && (SelIndex != CurrentSel)) begin
                    target_n   = SelIndex;
                    state_n    = ST_PENDING;
                    switch_now = frame_end;
                end else if (AutoCycle && frame_end && (dwell_cnt == DWELL_LAST)) begin
                    target_n   = CurrentSel + 2'd1;
                    state_n    = ST_PENDING;
                    switch_now = 1'b1;
                end else if (!AutoCycle) begin
                    dwell_n = '0;
                end else if (frame_end) begin
                    dwell_n = dwell_cnt + DW'(1);
                end
            end
            ST_PENDING: begin
                if (SelValid && (SelIndex == CurrentSel)) begin
                    state_n = ST_ACTIVE;
                    dwell_n = '0;
                end else begin
                    if (SelValid) target_n = SelIndex;
                    switch_now = frame_end;
                end
            end
            ST_BLANK: begin
                if (SelValid) target_n = SelIndex;
                if (frame_end) begin
                    black_n = black_cnt + BW'(1);
                    if (black_cnt == BLACK_LAST) begin
                        sel_n   = target_n;
                        state_n = ST_ACTIVE;
                        dwell_n = '0;
                    end
                end
            end
            default: state_n = ST_ACTIVE;
        endcase
        // A switch taken at a frame end either hands over directly or starts blanking.
        if (switch_now) begin
            dwell_n = '0;
            black_n = '0;
            if (BLACK_FRAMES == 0) begin
                sel_n   = target_n;
                state_n = ST_ACTIVE;
            end else begin
                state_n = ST_BLANK;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_ACTIVE;
            CurrentSel <= '0;
            target     <= '0;
            x          <= '0;
            y          <= '0;
            dwell_cnt  <= '0;
            black_cnt  <= '0;
            FrameDone  <= 1'b0;
            FrameCount <= '0;
        end else begin
            state      <= state_n;
            CurrentSel <= sel_n;
            target     <= target_n;
            dwell_cnt  <= dwell_n;
            black_cnt  <= black_n;
            FrameDone  <= frame_end;
            if (frame_end) FrameCount <= FrameCount + 16'd1;
            if (VideoReady) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_video_source_scheduler.sv
// Bench for video_source_scheduler: vector table, directed corner sequences and
// randomized traffic checked against a frame-level reference model.
module tb_video_source_scheduler;
    localparam int H = 4;
    localparam int V = 2;
    localparam int DWELL = 2;
    localparam int BLACK = 1;
    localparam int FRAME_PIX = H * V;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        VideoReady = 1'b0;
    logic [23:0] Src0Video = 24'h000011;
    logic [23:0] Src1Video = 24'h000022;
    logic [23:0] Src2Video = 24'h000033;
    logic [23:0] Src3Video = 24'h000044;
    logic [3:0]  SrcReady;
    logic [23:0] video;
    logic        AutoCycle = 1'b0;
    logic        SelValid = 1'b0;
    logic [1:0]  SelIndex = 2'd0;
    logic        SelBusy;
    logic [1:0]  CurrentSel;
    logic        FrameDone;
    logic [15:0] FrameCount;

    video_source_scheduler #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DWELL_FRAMES(DWELL), .BLACK_FRAMES(BLACK)
    ) dut (
        .Clock(Clock), .Reset(Reset), .VideoReady(VideoReady),
        .Src0Video(Src0Video), .Src1Video(Src1Video),
        .Src2Video(Src2Video), .Src3Video(Src3Video),
        .SrcReady(SrcReady), .video(video), .AutoCycle(AutoCycle),
        .SelValid(SelValid), .SelIndex(SelIndex), .SelBusy(SelBusy),
        .CurrentSel(CurrentSel), .FrameDone(FrameDone), .FrameCount(FrameCount)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: frame position, source shown, pending target (-1 none),
    // black frames still to show and frames shown under auto-cycle.
    int m_pix, m_sel, m_target, m_blank_left, m_shown, m_frames;
    bit m_fdone;

    // Outputs sampled in the most recent cycle
    logic [23:0] s_video;
    logic [3:0]  s_rdy;
    logic        s_busy, s_fd;
    logic [1:0]  s_sel;
    logic [15:0] s_fc;

    typedef struct packed {
        logic        vr;
        logic        sv;
        logic [1:0]  si;
        logic        ac;
        logic [23:0] ev;
        logic [3:0]  er;
        logic        eb;
        logic [1:0]  es;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [23:0] src_const(input int i);
        case (i)
            0:       return 24'h000011;
            1:       return 24'h000022;
            2:       return 24'h000033;
            default: return 24'h000044;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pix = 0; m_sel = 0; m_target = -1; m_blank_left = 0;
        m_shown = 0; m_frames = 0; m_fdone = 0;
    endtask

    task automatic model_step(input logic vr, input logic sv, input logic [1:0] si, input logic ac);
        bit fe;
        bit go;
        fe = vr && (m_pix == FRAME_PIX - 1);
        go = 0;
        m_fdone = fe;
        if (fe) m_frames = (m_frames + 1) % 65536;
        if (vr) m_pix = (m_pix + 1) % FRAME_PIX;
        if (m_blank_left > 0) begin
            if (sv) m_target = int'(si);
            if (fe) begin
                m_blank_left--;
                if (m_blank_left == 0) begin
                    m_sel = m_target; m_target = -1; m_shown = 0;
                end
            end
        end else if (m_target >= 0) begin
            if (sv && int'(si) == m_sel) begin
                m_target = -1; m_shown = 0;
            end else begin
                if (sv) m_target = int'(si);
                go = fe;
            end
        end else begin
            if (sv && int'(si) != m_sel) begin
                m_target = int'(si); go = fe;
            end else if (!ac) begin
                m_shown = 0;
            end else if (fe) begin
                m_shown++;
                if (m_shown == DWELL) begin
                    m_target = (m_sel + 1) % 4; go = 1;
                end
            end
        end
        if (go) begin
            m_shown = 0;
            if (BLACK == 0) begin
                m_sel = m_target; m_target = -1;
            end else begin
                m_blank_left = BLACK;
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; VideoReady = 0; SelValid = 0; SelIndex = 0; AutoCycle = 0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
    endtask

    // Called just after a rising edge; drives inputs, samples at the falling edge.
    task automatic cycle(input logic vr, input logic sv, input logic [1:0] si, input logic ac);
        bit blank;
        VideoReady = vr; SelValid = sv; SelIndex = si; AutoCycle = ac;
        @(negedge Clock);
        s_video = video; s_rdy = SrcReady; s_busy = SelBusy;
        s_sel = CurrentSel; s_fd = FrameDone; s_fc = FrameCount;
        blank = (m_blank_left > 0);
        chk("model_video", 32'(s_video), 32'(blank ? 24'h0 : src_const(m_sel)));
        chk("model_ready", 32'(s_rdy), 32'((blank || !vr) ? 4'b0 : (4'b0001 << m_sel)));
        chk("model_busy", 32'(s_busy), 32'(blank || (m_target >= 0)));
        chk("model_sel", 32'(s_sel), 32'(m_sel));
        chk("model_framedone", 32'(s_fd), 32'(m_fdone));
        chk("model_framecount", 32'(s_fc), 32'(m_frames));
        model_step(vr, sv, si, ac);
        @(posedge Clock); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_pulses;
        int zero_video;
        int blank_cycles;
        int prev;
        int changes[$];
        int change_cyc[$];
        int px_cnt[4];

        // Row 0 checks reset state with VideoReady low; rows 1..20 are pixels 0..19.
        for (int i = 0; i < 21; i++) begin
            int p;
            p = i - 1;
            tbl[i].vr = (i != 0);
            tbl[i].sv = (i == 4);
            tbl[i].si = 2'd2;
            tbl[i].ac = 1'b0;
            if (i == 0) begin
                tbl[i].ev = 24'h000011; tbl[i].er = 4'b0000; tbl[i].eb = 1'b0; tbl[i].es = 2'd0;
            end else if (p <= 3) begin
                tbl[i].ev = 24'h000011; tbl[i].er = 4'b0001; tbl[i].eb = 1'b0; tbl[i].es = 2'd0;
            end else if (p <= 7) begin
                tbl[i].ev = 24'h000011; tbl[i].er = 4'b0001; tbl[i].eb = 1'b1; tbl[i].es = 2'd0;
            end else if (p <= 15) begin
                tbl[i].ev = 24'h000000; tbl[i].er = 4'b0000; tbl[i].eb = 1'b1; tbl[i].es = 2'd0;
            end else begin
                tbl[i].ev = 24'h000033; tbl[i].er = 4'b0100; tbl[i].eb = 1'b0; tbl[i].es = 2'd2;
            end
        end

        repeat (2) @(posedge Clock);
        #1;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].vr, tbl[i].sv, tbl[i].si, tbl[i].ac);
            chk("tbl_video", 32'(s_video), 32'(tbl[i].ev));
            chk("tbl_ready", 32'(s_rdy), 32'(tbl[i].er));
            chk("tbl_busy", 32'(s_busy), 32'(tbl[i].eb));
            chk("tbl_sel", 32'(s_sel), 32'(tbl[i].es));
        end

        // Continuous streaming from source 0: three frames in 24 pixels.
        do_reset();
        fd_pulses = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1, 0, 0, 0);
            if (s_fd) fd_pulses++;
        end
        cycle(0, 0, 0, 0);
        if (s_fd) fd_pulses++;
        chk("stream_framedone_pulses", 32'(fd_pulses), 32'd3);
        chk("stream_framecount", 32'(s_fc), 32'd3);

        // Auto-cycle: each source for two frames, one black frame between.
        do_reset();
        prev = 0; blank_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1, 0, 0, 1);
            if (s_video == 24'h0) blank_cycles++;
            if (int'(s_sel) != prev) begin
                changes.push_back(int'(s_sel));
                change_cyc.push_back(i);
                prev = int'(s_sel);
            end
        end
        chk("auto_num_changes", 32'(changes.size()), 32'd4);
        for (int k = 0; k < 4 && k < changes.size(); k++) begin
            chk("auto_order", 32'(changes[k]), 32'((k + 1) % 4));
            chk("auto_change_cycle", 32'(change_cyc[k]), 32'(24 * (k + 1)));
        end
        chk("auto_blank_cycles", 32'(blank_cycles), 32'd32);

        // Retarget while pending: 2 then 1, source 1 wins after the blank.
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 2, 0);
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 13; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("retarget_sel", 32'(s_sel), 32'd1);
        chk("retarget_video", 32'(s_video), 32'h22);

        // Cancel while pending by requesting the current source.
        do_reset();
        cycle(1, 1, 3, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        chk("cancel_busy", 32'(s_busy), 32'd0);
        zero_video = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0, 0);
            if (s_video == 24'h0) zero_video++;
        end
        chk("cancel_no_black", 32'(zero_video), 32'd0);
        chk("cancel_sel", 32'(s_sel), 32'd0);

        // Request on the exact frame-end cycle blanks from the next pixel.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, 2, 0);
        cycle(1, 0, 0, 0);
        chk("fe_req_video", 32'(s_video), 32'h0);
        chk("fe_req_busy", 32'(s_busy), 32'd1);
        chk("fe_req_ready", 32'(s_rdy), 32'h0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Reset during blanking returns to source 0 immediately.
        do_reset();
        cycle(0, 0, 0, 0);
        chk("rst_blank_sel", 32'(s_sel), 32'd0);
        chk("rst_blank_busy", 32'(s_busy), 32'd0);
        chk("rst_blank_fc", 32'(s_fc), 32'd0);
        chk("rst_blank_video", 32'(s_video), 32'h11);

        // Randomized traffic with gapped VideoReady.
        begin
            logic ac;
            ac = 1'b0;
            do_reset();
            prev = 0;
            for (int s = 0; s < 4; s++) px_cnt[s] = 0;
            for (int i = 0; i < 3000; i++) begin
                logic vr, sv;
                logic [1:0] si;
                if (i == 1500) begin
                    do_reset();
                    prev = 0;
                    for (int s = 0; s < 4; s++) px_cnt[s] = 0;
                end
                if ($urandom_range(0, 199) == 0) ac = ~ac;
                vr = ($urandom_range(0, 9) < 7);
                sv = ($urandom_range(0, 39) == 0);
                si = 2'($urandom_range(0, 3));
                cycle(vr, sv, si, ac);
                if (int'(s_sel) != prev) begin
                    chk("rand_aligned_switch", 32'(px_cnt[prev] % FRAME_PIX), 32'd0);
                    prev = int'(s_sel);
                end
                for (int s = 0; s < 4; s++) if (s_rdy[s]) px_cnt[s]++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
